div_frac_tick: RTL and testbench



---
 rtl/div_frac_tick.sv | 94 +++++++++
 tb/tb_div_frac_tick.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_frac_tick.sv
// Tick generator that replays buffered divider quotients as evenly paced one-cycle strobes.
// Each popped quotient Q (0 treated as 1) sets the length, in enabled cycles, of the next period.
module div_frac_tick #(
  parameter int DATA_W      = 32,
  parameter int FIFO_ADDR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DATA_W-1:0]      quotient_in,
  input  logic                   valid_in,
  output logic                   tick,
  output logic [DATA_W-1:0]      period_out,
  output logic                   busy,
  output logic [FIFO_ADDR_W:0]   level,
  output logic                   overflow
);

  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W:0] DEPTH_L = (FIFO_ADDR_W + 1)'(DEPTH);
  localparam logic [FIFO_ADDR_W:0] ONE_L   = (FIFO_ADDR_W + 1)'(1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [FIFO_ADDR_W-1:0]  wr_ptr;
  logic [FIFO_ADDR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0]       cnt;
  logic [DATA_W-1:0]       head;
  logic                    period_end;
  logic                    pop;
  logic                    push;

  // A zero-length period is meaningless for a clock enable; stretch it to one cycle.
  function automatic logic [DATA_W-1:0] eff_period(input logic [DATA_W-1:0] q);
    return (q == '0) ? DATA_W'(1) : q;
  endfunction

  assign head       = mem[rd_ptr];
  assign period_end = (state == COUNT) && (cnt == DATA_W'(1));
  assign pop        = en && (level != '0) && ((state == IDLE) || period_end);
  // A full FIFO still accepts a word when a pop frees a slot on the same edge.
  assign push       = valid_in && ((level < DEPTH_L) || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= quotient_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
      if (valid_in && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      period_out <= '0;
      tick       <= 1'b0;
      busy       <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
    end else begin
      tick <= period_end;
      if (pop) begin
        cnt        <= eff_period(head);
        period_out <= eff_period(head);
        state      <= COUNT;
        busy       <= 1'b1;
      end else if (period_end) begin
        cnt   <= '0;
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state == COUNT) begin
        cnt <= cnt - DATA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_div_frac_tick.sv
// Self-checking bench for div_frac_tick: directed scenarios plus randomized traffic
// compared against an event-time reference model (period ends at pop edge + Q enabled edges).
module tb_div_frac_tick;

  localparam int DATA_W = 32;
  localparam int AW     = 2;
  localparam int DEPTH  = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [DATA_W-1:0] quotient_in;
  logic              valid_in;
  logic              tick;
  logic [DATA_W-1:0] period_out;
  logic              busy;
  logic [AW:0]       level;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  longint            ecount;
  longint            next_end;
  logic              exp_tick;
  logic              exp_busy;
  logic              exp_over;
  logic [AW:0]       exp_level;
  logic [DATA_W-1:0] exp_period;

  div_frac_tick #(.DATA_W(DATA_W), .FIFO_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .quotient_in(quotient_in), .valid_in(valid_in),
    .tick(tick), .period_out(period_out), .busy(busy), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    ecount = 0; next_end = -1;
    exp_tick = 1'b0; exp_busy = 1'b0; exp_over = 1'b0; exp_level = '0; exp_period = '0;
  endtask

  task automatic model_step();
    longint qv;
    if (en) begin
      ecount++;
      exp_tick = (next_end == ecount);
      if (exp_tick) next_end = -1;
      if (next_end < 0 && mq.size() > 0) begin
        qv = longint'(mq.pop_front());
        if (qv == 0) qv = 1;
        exp_period = DATA_W'(qv);
        next_end = ecount + qv;
      end
    end else begin
      exp_tick = 1'b0;
    end
    if (valid_in) begin
      if (mq.size() < DEPTH) mq.push_back(quotient_in);
      else exp_over = 1'b1;
    end
    exp_busy  = (next_end >= 0);
    exp_level = (AW + 1)'(mq.size());
  endtask

  // Drive one cycle of inputs; returns at the negedge following the sampling edge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] q, input logic e);
    valid_in = v; quotient_in = q; en = e;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    valid_in = 1'b0; en = 1'b0; quotient_in = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    valid_in = 1'b0; en = 1'b0; quotient_in = '0;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({tick, busy, level, overflow, period_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: tick=%0b busy=%0b level=%0d ovf=%0b period=%0d, required all 0",
               tick, busy, level, overflow, period_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    cycle(1'b1, 5, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, 0, 1'b1);
      checks++;
      if (tick !== (k == 6)) begin
        errors++; $display("FAIL single_tick k=%0d: got %0b required %0b", k, tick, (k == 6));
      end
      if (k == 6) begin
        checks++;
        if (period_out !== 5 || busy !== 1'b0 || level !== 0) begin
          errors++;
          $display("FAIL single_end: period=%0d busy=%0b level=%0d, required 5 0 0", period_out, busy, level);
        end
      end
      checks++;
      if ({tick, busy, level, overflow, period_out} !== {exp_tick, exp_busy, exp_level, exp_over, exp_period}) begin
        errors++;
        $display("FAIL single_model k=%0d: got t%0b b%0b l%0d o%0b p%0d required t%0b b%0b l%0d o%0b p%0d", k,
                 tick, busy, level, overflow, period_out, exp_tick, exp_busy, exp_level, exp_over, exp_period);
      end
    end
  endtask

  task automatic test_back_to_back();
    int tk[$];
    int peak = 0;
    int gaps = 0;
    logic [DATA_W-1:0] pat [3] = '{3, 4, 3};
    apply_reset();
    for (int t = 0; t < 18; t++) begin
      if (t < 3) cycle(1'b1, pat[t], 1'b1);
      else       cycle(1'b0, 0, 1'b1);
      if (tick) tk.push_back(t);
      if (int'(level) > peak) peak = int'(level);
      if (t >= 1 && t < 11 && busy !== 1'b1) gaps++;
      checks++;
      if ({tick, busy, level, overflow, period_out} !== {exp_tick, exp_busy, exp_level, exp_over, exp_period}) begin
        errors++;
        $display("FAIL b2b_model t=%0d: got t%0b b%0b l%0d p%0d required t%0b b%0b l%0d p%0d", t,
                 tick, busy, level, period_out, exp_tick, exp_busy, exp_level, exp_period);
      end
    end
    checks++;
    if (tk.size() != 3 || tk[0] != 4 || tk[1] - tk[0] != 4 || tk[2] - tk[1] != 3) begin
      errors++; $display("FAIL b2b_spacing: %0d ticks, times %p, required 3 ticks at 4 8 11", tk.size(), tk);
    end
    checks++;
    if (peak < 2 || peak > 3) begin
      errors++; $display("FAIL b2b_peak_level: got %0d required 2..3", peak);
    end
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL b2b_no_gap: busy low %0d cycles, required 0", gaps);
    end
  endtask

  task automatic test_overflow();
    int tk[$];
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 2, 1'b0);
    checks++;
    if (level !== 4 || overflow !== 1'b1 || tick !== 1'b0) begin
      errors++; $display("FAIL ovf_fill: level=%0d ovf=%0b tick=%0b, required 4 1 0", level, overflow, tick);
    end
    for (int t = 1; t <= 12; t++) begin
      cycle(1'b0, 0, 1'b1);
      if (tick) tk.push_back(t);
      checks++;
      if ({tick, busy, level, overflow, period_out} !== {exp_tick, exp_busy, exp_level, exp_over, exp_period}) begin
        errors++;
        $display("FAIL ovf_model t=%0d: got t%0b b%0b l%0d o%0b required t%0b b%0b l%0d o%0b", t,
                 tick, busy, level, overflow, exp_tick, exp_busy, exp_level, exp_over);
      end
    end
    checks++;
    if (tk.size() != 4 || tk[0] != 3 || tk[1] != 5 || tk[2] != 7 || tk[3] != 9) begin
      errors++; $display("FAIL ovf_ticks: times %p, required 3 5 7 9", tk);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %0b required 1", overflow);
    end
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 3, 1'b0);
    checks++;
    if (level !== 4 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_setup: level=%0d ovf=%0b, required 4 0", level, overflow);
    end
    cycle(1'b1, 7, 1'b1);
    checks++;
    if (level !== 4 || overflow !== 1'b0 || busy !== 1'b1 || period_out !== 3) begin
      errors++;
      $display("FAIL full_push_pop: level=%0d ovf=%0b busy=%0b period=%0d, required 4 0 1 3",
               level, overflow, busy, period_out);
    end
    for (int t = 0; t < 20; t++) begin
      cycle(1'b0, 0, 1'b1);
      checks++;
      if ({tick, busy, level, overflow, period_out} !== {exp_tick, exp_busy, exp_level, exp_over, exp_period}) begin
        errors++;
        $display("FAIL full_model t=%0d: got t%0b b%0b l%0d p%0d required t%0b b%0b l%0d p%0d", t,
                 tick, busy, level, period_out, exp_tick, exp_busy, exp_level, exp_period);
      end
    end
  endtask

  task automatic test_zero_and_one();
    int tk[$];
    apply_reset();
    cycle(1'b1, 0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, 0, 1'b1);
      checks++;
      if (tick !== (k == 2)) begin
        errors++; $display("FAIL zero_tick k=%0d: got %0b required %0b", k, tick, (k == 2));
      end
      if (k == 1) begin
        checks++;
        if (period_out !== 1) begin
          errors++; $display("FAIL zero_period: got %0d required 1", period_out);
        end
      end
    end
    for (int t = 0; t < 9; t++) begin
      if (t < 3) cycle(1'b1, 1, 1'b1);
      else       cycle(1'b0, 0, 1'b1);
      if (tick) tk.push_back(t);
    end
    checks++;
    if (tk.size() != 3 || tk[0] != 2 || tk[1] != 3 || tk[2] != 4) begin
      errors++; $display("FAIL one_consecutive: times %p, required 2 3 4", tk);
    end
  endtask

  task automatic test_enable_stall();
    int tk[$];
    apply_reset();
    cycle(1'b1, 10, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 0, (k < 4 || k > 6));
      if (tick) tk.push_back(k);
      checks++;
      if ({tick, busy, level, period_out} !== {exp_tick, exp_busy, exp_level, exp_period}) begin
        errors++;
        $display("FAIL stall_model k=%0d: got t%0b b%0b l%0d p%0d required t%0b b%0b l%0d p%0d", k,
                 tick, busy, level, period_out, exp_tick, exp_busy, exp_level, exp_period);
      end
    end
    checks++;
    if (tk.size() != 1 || tk[0] != 14) begin
      errors++; $display("FAIL stall_delay: times %p, required 14", tk);
    end
  endtask

  task automatic test_reset_mid();
    int nt = 0;
    apply_reset();
    cycle(1'b1, 10, 1'b1);
    cycle(1'b1, 7, 1'b1);
    cycle(1'b1, 7, 1'b1);
    cycle(1'b0, 0, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({tick, busy, level, overflow, period_out} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: tick=%0b busy=%0b level=%0d ovf=%0b period=%0d, required all 0",
               tick, busy, level, overflow, period_out);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({tick, busy, level, overflow, period_out} !== '0) begin
      errors++;
      $display("FAIL midreset_held: tick=%0b busy=%0b level=%0d period=%0d, required all 0",
               tick, busy, level, period_out);
    end
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cycle(1'b0, 0, 1'b1);
      if (tick) nt++;
    end
    checks++;
    if (nt != 0 || level !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_discard: ticks=%0d level=%0d busy=%0b, required 0 0 0", nt, level, busy);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int t = 0; t < 600; t++) begin
      cycle(($urandom % 3) == 0, DATA_W'($urandom_range(0, 6)), ($urandom % 5) != 0);
      checks++;
      if ({tick, busy, level, overflow, period_out} !== {exp_tick, exp_busy, exp_level, exp_over, exp_period}) begin
        errors++;
        $display("FAIL random_model t=%0d: got t%0b b%0b l%0d o%0b p%0d required t%0b b%0b l%0d o%0b p%0d", t,
                 tick, busy, level, overflow, period_out, exp_tick, exp_busy, exp_level, exp_over, exp_period);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid_in = 1'b0; quotient_in = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_zero_and_one();
    test_enable_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
